csr_trap_sequencer: RTL and testbench
=====================================

Name: csr_trap_sequencer

Overview:
- Consumes the exception raised by the CSR register file on an illegal CSR access (e.g. a debug-only CSR, addr[11:4]==8'h7b, accessed outside debug mode; cause ILLEGAL_INSTR=2).
- Sequences trap entry:
  - captures cause, tval and PC;
  - flushes the pipeline;
  - writes mcause/mepc/mtval through a CSR write port;
  - redirects fetch to the trap vector.
- Sits between the CSR file exception output and the frontend/commit stage.

Parameters:
- XLEN, 64, data/address width of cause, tval, pc, mtvec.
- DBG_EXC_ADDR, 64'h0000_0000_0000_0808, redirect target for an exception taken while in debug mode.
- CNT_W, 32, width of the saturating trap counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ex_valid_i  in  1  exception request from CSR file
- ex_ready_o  out  1  sequencer can accept an exception
- ex_cause_i  in  XLEN  exception cause
- ex_tval_i  in  XLEN  trap value (faulting instruction or address)
- ex_pc_i  in  XLEN  PC of the faulting instruction
- debug_mode_i  in  1  core is in debug mode
- mtvec_i  in  XLEN  current mtvec CSR value
- csr_wr_valid_o  out  1  CSR write request
- csr_wr_addr_o  out  12  CSR write address
- csr_wr_data_o  out  XLEN  CSR write data
- csr_wr_ready_i  in  1  CSR file accepts the write
- flush_o  out  1  one-cycle pipeline flush pulse
- redirect_valid_o  out  1  fetch redirect request
- redirect_pc_o  out  XLEN  redirect target
- redirect_ready_i  in  1  frontend accepts the redirect
- busy_o  out  1  state != IDLE
- trap_count_o  out  CNT_W  number of traps accepted, saturating

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE;
  - all outputs 0 except ex_ready_o=1;
  - capture registers and trap_count_o = 0.
  - A reset during any state aborts the sequence; no partial CSR write is retried.
- Accepting an exception:
  - ex_ready_o = (state==IDLE).
  - Accept occurs when ex_valid_i && ex_ready_o.
  - On accept, register cause, tval, pc, debug_mode_i (snapshot) and mtvec_i, then go to FLUSH.
  - ex_valid_i while busy is ignored; the requester holds it.
  - trap_count_o increments on accept and saturates at all-ones.
- States:
  - IDLE: wait for accept.
  - FLUSH:
    - flush_o=1 for exactly one cycle;
    - next state is REDIRECT if the debug snapshot is 1, otherwise WR_CAUSE.
  - WR_CAUSE: csr_wr_valid_o=1, addr=12'h342, data=cause; advance on csr_wr_ready_i.
  - WR_EPC: addr=12'h341, data={pc[XLEN-1:1],1'b0}; advance on ready.
  - WR_TVAL: addr=12'h343, data=tval; advance on ready, go to REDIRECT.
  - REDIRECT:
    - redirect_valid_o=1;
    - on redirect_ready_i, return to IDLE. ex_ready_o is 1 in the following cycle.
- CSR write handshake:
  - valid/addr/data stay stable until ready.
  - Valid drops in the cycle after the handshake only if the next state is not a write state; it stays high across WR_CAUSE→WR_EPC→WR_TVAL with updated addr/data.
  - If ready is already high when valid rises, each write takes 1 cycle.
- Redirect target:
  - In debug mode: DBG_EXC_ADDR.
  - Otherwise the base is {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==2'b01 and cause[XLEN-1]==1 (interrupt): target = base + (cause[5:0] << 2).
  - Otherwise: target = base.
  - mtvec[1:0] of 2'b10 or 2'b11 is treated as direct.
  - Arithmetic is modulo 2^XLEN.
- Minimum latency, accept to redirect_valid_o:
  - 5 cycles in normal mode, with all readies high;
  - 2 cycles in debug mode.

Decomposition:
- Shared package csr_trap_pkg holds:
  - state enum trap_state_e (IDLE, FLUSH, WR_CAUSE, WR_EPC, WR_TVAL, REDIRECT);
  - CSR address constants CSR_MCAUSE, CSR_MEPC, CSR_MTVAL;
  - cause constant ILLEGAL_INSTR=2.
- Sub-module trap_vector_calc is combinational: mtvec, cause and debug in, target out.
- The FSM and counter stay in the top level.

Test Plan:
- Illegal access: cause=2, tval=64'h7b2, pc=64'h8000_0104, mtvec=64'h8000_0000, debug=0, readies high.
  - flush pulse one cycle after accept;
  - writes 0x342←2, 0x341←0x8000_0104, 0x343←0x7b2;
  - redirect_pc_o=0x8000_0000;
  - trap_count_o=1.
- Debug mode exception: debug=1, cause=2.
  - flush only, no CSR writes;
  - redirect_pc_o=0x808, 2 cycles after accept.
- Vectored interrupt: mtvec=64'h8000_0001, cause=64'h8000_0000_0000_0007.
  - redirect_pc_o=0x8000_001C.
- Backpressure: csr_wr_ready_i low 3 cycles on each write, redirect_ready_i low 2 cycles.
  - addr/data stable throughout;
  - ex_valid_i asserted mid-sequence is not accepted until IDLE.
- Reset mid-WR_EPC: assert rst_i asynchronously.
  - outputs 0 immediately;
  - ex_ready_o=1;
  - trap_count_o=0;
  - a new exception afterwards completes normally.
- Counter saturation: preload by CNT_W=4 build plus 17 traps.
  - trap_count_o holds 4'hF.

Source files
------------

// File: rtl/csr_trap_pkg.sv
// Shared types and constants for the CSR trap-entry sequencer.
package csr_trap_pkg;

  // Sequencer states; the encoding is fixed so the state is easy to read in waves.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    WR_CAUSE = 3'd2,
    WR_EPC   = 3'd3,
    WR_TVAL  = 3'd4,
    REDIRECT = 3'd5
  } trap_state_e;

  // Machine-mode trap CSR addresses written during trap entry.
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  // Cause code raised by the CSR file on an illegal CSR access.
  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  // True for the states that drive the CSR write port.
  function automatic logic is_wr_state(input trap_state_e s);
    return (s == WR_CAUSE) || (s == WR_EPC) || (s == WR_TVAL);
  endfunction

endpackage

// File: rtl/csr_trap_sequencer_vec.sv
// Combinational trap vector calculation: debug override, direct or vectored mtvec.
module trap_vector_calc
  import csr_trap_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] DBG_EXC_ADDR = 64'h0000_0000_0000_0808
) (
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic            debug_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] base_s;
  logic [XLEN-1:0] offset_s;
  logic            vectored_s;
  logic            cause_unused_s;

  assign base_s     = {mtvec_i[XLEN-1:2], 2'b00};
  // Only the low six cause bits select a vector slot; each slot is one word.
  assign offset_s   = {{(XLEN-8){1'b0}}, cause_i[5:0], 2'b00};
  // Modes 2'b10/2'b11 are reserved and fall back to direct.
  assign vectored_s = (mtvec_i[1:0] == 2'b01) && cause_i[XLEN-1];
  // The middle cause bits never influence the target.
  assign cause_unused_s = ^cause_i[XLEN-2:6];

  // Select the redirect target; addition wraps modulo 2^XLEN.
  always_comb begin
    target_o = base_s;
    if (debug_i) begin
      target_o = DBG_EXC_ADDR;
    end else if (vectored_s) begin
      target_o = base_s + offset_s;
    end else begin
      target_o = base_s;
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Trap-entry sequencer: captures an exception from the CSR file, flushes the
// pipeline, writes mcause/mepc/mtval and redirects fetch to the trap vector.
// All outputs are registered and decoded from the next state, so they change
// in the same cycle the state does.
module csr_trap_sequencer
  import csr_trap_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] DBG_EXC_ADDR = 64'h0000_0000_0000_0808,
  parameter int              CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [XLEN-1:0]  ex_cause_i,
  input  logic [XLEN-1:0]  ex_tval_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             debug_mode_i,
  input  logic [XLEN-1:0]  mtvec_i,
  output logic             csr_wr_valid_o,
  output logic [11:0]      csr_wr_addr_o,
  output logic [XLEN-1:0]  csr_wr_data_o,
  input  logic             csr_wr_ready_i,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] trap_count_o
);

  trap_state_e      state_r, state_next_s;
  logic [XLEN-1:0]  cause_r, tval_r, pc_r, mtvec_r;
  logic             debug_r;
  logic [CNT_W-1:0] count_r;

  logic             ex_ready_r, flush_r, csr_wr_valid_r, redirect_valid_r, busy_r;
  logic [11:0]      csr_wr_addr_r;
  logic [XLEN-1:0]  csr_wr_data_r, redirect_pc_r;

  logic             accept_s;
  logic [11:0]      wr_addr_next_s;
  logic [XLEN-1:0]  wr_data_next_s;
  logic [XLEN-1:0]  target_s;

  assign accept_s = ex_valid_i && ex_ready_r;

  trap_vector_calc #(
    .XLEN         (XLEN),
    .DBG_EXC_ADDR (DBG_EXC_ADDR)
  ) u_vec (
    .mtvec_i  (mtvec_r),
    .cause_i  (cause_r),
    .debug_i  (debug_r),
    .target_o (target_s)
  );

  // Next-state logic; each write or redirect state waits for its ready.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:     if (accept_s)         state_next_s = FLUSH;    else state_next_s = IDLE;
      FLUSH:    if (debug_r)          state_next_s = REDIRECT; else state_next_s = WR_CAUSE;
      WR_CAUSE: if (csr_wr_ready_i)   state_next_s = WR_EPC;   else state_next_s = WR_CAUSE;
      WR_EPC:   if (csr_wr_ready_i)   state_next_s = WR_TVAL;  else state_next_s = WR_EPC;
      WR_TVAL:  if (csr_wr_ready_i)   state_next_s = REDIRECT; else state_next_s = WR_TVAL;
      REDIRECT: if (redirect_ready_i) state_next_s = IDLE;     else state_next_s = REDIRECT;
      default:                        state_next_s = IDLE;
    endcase
  end

  // CSR write address/data for the upcoming state; mepc always has bit 0 clear.
  always_comb begin
    wr_addr_next_s = 12'h000;
    wr_data_next_s = {XLEN{1'b0}};
    case (state_next_s)
      WR_CAUSE: begin
        wr_addr_next_s = CSR_MCAUSE;
        wr_data_next_s = cause_r;
      end
      WR_EPC: begin
        wr_addr_next_s = CSR_MEPC;
        wr_data_next_s = {pc_r[XLEN-1:1], 1'b0};
      end
      WR_TVAL: begin
        wr_addr_next_s = CSR_MTVAL;
        wr_data_next_s = tval_r;
      end
      default: begin
        wr_addr_next_s = 12'h000;
        wr_data_next_s = {XLEN{1'b0}};
      end
    endcase
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Snapshot the exception and mode bits at accept so later input changes are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cause_r <= {XLEN{1'b0}};
      tval_r  <= {XLEN{1'b0}};
      pc_r    <= {XLEN{1'b0}};
      mtvec_r <= {XLEN{1'b0}};
      debug_r <= 1'b0;
    end else if (accept_s) begin
      cause_r <= ex_cause_i;
      tval_r  <= ex_tval_i;
      pc_r    <= ex_pc_i;
      mtvec_r <= mtvec_i;
      debug_r <= debug_mode_i;
    end
  end

  // Saturating count of accepted traps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (accept_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered outputs decoded from the next state; held stable while waiting for ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_ready_r       <= 1'b1;
      flush_r          <= 1'b0;
      csr_wr_valid_r   <= 1'b0;
      csr_wr_addr_r    <= 12'h000;
      csr_wr_data_r    <= {XLEN{1'b0}};
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {XLEN{1'b0}};
      busy_r           <= 1'b0;
    end else begin
      ex_ready_r       <= (state_next_s == IDLE);
      flush_r          <= (state_next_s == FLUSH);
      csr_wr_valid_r   <= is_wr_state(state_next_s);
      csr_wr_addr_r    <= wr_addr_next_s;
      csr_wr_data_r    <= wr_data_next_s;
      redirect_valid_r <= (state_next_s == REDIRECT);
      redirect_pc_r    <= (state_next_s == REDIRECT) ? target_s : {XLEN{1'b0}};
      busy_r           <= (state_next_s != IDLE);
    end
  end

  assign ex_ready_o       = ex_ready_r;
  assign flush_o          = flush_r;
  assign csr_wr_valid_o   = csr_wr_valid_r;
  assign csr_wr_addr_o    = csr_wr_addr_r;
  assign csr_wr_data_o    = csr_wr_data_r;
  assign redirect_valid_o = redirect_valid_r;
  assign redirect_pc_o    = redirect_pc_r;
  assign busy_o           = busy_r;
  assign trap_count_o     = count_r;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed self-checking bench for csr_trap_sequencer (built with a 4-bit trap counter).
module tb_csr_trap_sequencer;
  import csr_trap_pkg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             ex_valid_i;
  logic             ex_ready_o;
  logic [XLEN-1:0]  ex_cause_i, ex_tval_i, ex_pc_i, mtvec_i;
  logic             debug_mode_i;
  logic             csr_wr_valid_o;
  logic [11:0]      csr_wr_addr_o;
  logic [XLEN-1:0]  csr_wr_data_o;
  logic             csr_wr_ready_i;
  logic             flush_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             redirect_ready_i;
  logic             busy_o;
  logic [CNT_W-1:0] trap_count_o;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_count = 4'h0;

  csr_trap_sequencer #(
    .XLEN         (XLEN),
    .DBG_EXC_ADDR (64'h0000_0000_0000_0808),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_cause_i       (ex_cause_i),
    .ex_tval_i        (ex_tval_i),
    .ex_pc_i          (ex_pc_i),
    .debug_mode_i     (debug_mode_i),
    .mtvec_i          (mtvec_i),
    .csr_wr_valid_o   (csr_wr_valid_o),
    .csr_wr_addr_o    (csr_wr_addr_o),
    .csr_wr_data_o    (csr_wr_data_o),
    .csr_wr_ready_i   (csr_wr_ready_i),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .busy_o           (busy_o),
    .trap_count_o     (trap_count_o)
  );

  // 10 ns clock; outputs are sampled and inputs driven on the falling edge.
  always #5 clk_i = ~clk_i;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == 4'hF) ? 4'hF : c + 4'h1;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; ex_valid_i = 1'b0; ex_cause_i = 64'h0; ex_tval_i = 64'h0; ex_pc_i = 64'h0;
    mtvec_i = 64'h0; debug_mode_i = 1'b0; csr_wr_ready_i = 1'b1; redirect_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if ({flush_o, csr_wr_valid_o, redirect_valid_o} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {flush_o, csr_wr_valid_o, redirect_valid_o}); end
    checks++; if (redirect_pc_o !== 64'h0 || csr_wr_data_o !== 64'h0 || csr_wr_addr_o !== 12'h0) begin failures++; $display("FAIL reset_data pc=%h data=%h addr=%h exp=0", redirect_pc_o, csr_wr_data_o, csr_wr_addr_o); end
    checks++; if (trap_count_o !== 4'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", trap_count_o); end
  endtask

  // Full normal-mode trap with all readies high; must be entered on a falling edge in IDLE.
  task automatic run_normal_trap(input logic [63:0] cause, input logic [63:0] tval, input logic [63:0] pc,
                                 input logic [63:0] mtvec, input logic [63:0] exp_pc, input string tag);
    logic [63:0] exp_epc;
    exp_epc = {pc[63:1], 1'b0};
    ex_valid_i = 1'b1; ex_cause_i = cause; ex_tval_i = tval; ex_pc_i = pc; mtvec_i = mtvec;
    debug_mode_i = 1'b0; csr_wr_ready_i = 1'b1; redirect_ready_i = 1'b1;
    @(negedge clk_i);
    ex_valid_i = 1'b0;
    exp_count = sat_inc(exp_count);
    checks++; if (flush_o !== 1'b1 || csr_wr_valid_o !== 1'b0 || ex_ready_o !== 1'b0) begin failures++; $display("FAIL %s_flush flush=%b wr=%b rdy=%b exp=1,0,0", tag, flush_o, csr_wr_valid_o, ex_ready_o); end
    checks++; if (trap_count_o !== exp_count) begin failures++; $display("FAIL %s_count got=%h exp=%h", tag, trap_count_o, exp_count); end
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b0 || csr_wr_valid_o !== 1'b1 || csr_wr_addr_o !== 12'h342 || csr_wr_data_o !== cause) begin failures++; $display("FAIL %s_mcause flush=%b v=%b addr=%h data=%h exp=0,1,342,%h", tag, flush_o, csr_wr_valid_o, csr_wr_addr_o, csr_wr_data_o, cause); end
    @(negedge clk_i);
    checks++; if (csr_wr_valid_o !== 1'b1 || csr_wr_addr_o !== 12'h341 || csr_wr_data_o !== exp_epc) begin failures++; $display("FAIL %s_mepc v=%b addr=%h data=%h exp=1,341,%h", tag, csr_wr_valid_o, csr_wr_addr_o, csr_wr_data_o, exp_epc); end
    @(negedge clk_i);
    checks++; if (csr_wr_valid_o !== 1'b1 || csr_wr_addr_o !== 12'h343 || csr_wr_data_o !== tval) begin failures++; $display("FAIL %s_mtval v=%b addr=%h data=%h exp=1,343,%h", tag, csr_wr_valid_o, csr_wr_addr_o, csr_wr_data_o, tval); end
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b1 || csr_wr_valid_o !== 1'b0 || redirect_pc_o !== exp_pc) begin failures++; $display("FAIL %s_redirect rv=%b wv=%b pc=%h exp=1,0,%h", tag, redirect_valid_o, csr_wr_valid_o, redirect_pc_o, exp_pc); end
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL %s_idle rv=%b rdy=%b busy=%b exp=0,1,0", tag, redirect_valid_o, ex_ready_o, busy_o); end
  endtask

  // Debug-mode trap: flush then straight to redirect at DBG_EXC_ADDR.
  task automatic run_debug_trap(input logic [63:0] cause, input string tag);
    ex_valid_i = 1'b1; ex_cause_i = cause; ex_tval_i = 64'h7b2; ex_pc_i = 64'h8000_0200; mtvec_i = 64'h8000_0001;
    debug_mode_i = 1'b1; csr_wr_ready_i = 1'b1; redirect_ready_i = 1'b1;
    @(negedge clk_i);
    ex_valid_i = 1'b0; debug_mode_i = 1'b0;
    exp_count = sat_inc(exp_count);
    checks++; if (flush_o !== 1'b1 || csr_wr_valid_o !== 1'b0) begin failures++; $display("FAIL %s_flush flush=%b wr=%b exp=1,0", tag, flush_o, csr_wr_valid_o); end
    checks++; if (trap_count_o !== exp_count) begin failures++; $display("FAIL %s_count got=%h exp=%h", tag, trap_count_o, exp_count); end
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b1 || csr_wr_valid_o !== 1'b0 || flush_o !== 1'b0 || redirect_pc_o !== 64'h808) begin failures++; $display("FAIL %s_redirect rv=%b wv=%b fl=%b pc=%h exp=1,0,0,808", tag, redirect_valid_o, csr_wr_valid_o, flush_o, redirect_pc_o); end
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1 || redirect_valid_o !== 1'b0) begin failures++; $display("FAIL %s_idle rdy=%b rv=%b exp=1,0", tag, ex_ready_o, redirect_valid_o); end
  endtask

  task automatic test_illegal_access();
    run_normal_trap(ILLEGAL_INSTR, 64'h7b2, 64'h8000_0104, 64'h8000_0000, 64'h8000_0000, "illegal");
  endtask

  task automatic test_debug_mode();
    run_debug_trap(ILLEGAL_INSTR, "debug");
  endtask

  task automatic test_vector_modes();
    run_normal_trap(64'h8000_0000_0000_0007, 64'h0, 64'h8000_0105, 64'h8000_0001, 64'h8000_001C, "vec_irq7");
    run_normal_trap(64'h8000_0000_0000_007F, 64'h0, 64'h8000_0300, 64'h8000_0001, 64'h8000_00FC, "vec_code_mask");
    run_normal_trap(64'h8000_0000_0000_0007, 64'h0, 64'h8000_0300, 64'h8000_0003, 64'h8000_0000, "mode3_direct");
    run_normal_trap(64'h8000_0000_0000_0007, 64'h0, 64'h8000_0300, 64'h8000_0012, 64'h8000_0010, "mode2_direct");
    run_normal_trap(64'h0000_0000_0000_0005, 64'h44, 64'h8000_0300, 64'h8000_0101, 64'h8000_0100, "vec_exception");
    run_normal_trap(64'h8000_0000_0000_0007, 64'h0, 64'h8000_0300, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_000C, "vec_wrap");
  endtask

  task automatic test_backpressure();
    logic [11:0] addrs [3];
    logic [63:0] datas [3];
    addrs[0] = 12'h342; addrs[1] = 12'h341; addrs[2] = 12'h343;
    datas[0] = 64'h2; datas[1] = 64'h8000_0104; datas[2] = 64'h7b2;
    ex_valid_i = 1'b1; ex_cause_i = 64'h2; ex_tval_i = 64'h7b2; ex_pc_i = 64'h8000_0104; mtvec_i = 64'h8000_0000;
    debug_mode_i = 1'b0; csr_wr_ready_i = 1'b0; redirect_ready_i = 1'b0;
    @(negedge clk_i);
    exp_count = sat_inc(exp_count);
    checks++; if (flush_o !== 1'b1 || trap_count_o !== exp_count) begin failures++; $display("FAIL bp_flush flush=%b count=%h exp=1,%h", flush_o, trap_count_o, exp_count); end
    // A second request is held by the requester for the rest of the sequence.
    ex_cause_i = 64'd11; ex_tval_i = 64'h0; ex_pc_i = 64'h1234; mtvec_i = 64'h4000_0000; debug_mode_i = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_i);
        checks++; if (csr_wr_valid_o !== 1'b1 || csr_wr_addr_o !== addrs[w] || csr_wr_data_o !== datas[w]) begin failures++; $display("FAIL bp_write%0d_%0d v=%b addr=%h data=%h exp=1,%h,%h", w, i, csr_wr_valid_o, csr_wr_addr_o, csr_wr_data_o, addrs[w], datas[w]); end
        checks++; if (ex_ready_o !== 1'b0 || trap_count_o !== exp_count) begin failures++; $display("FAIL bp_hold%0d_%0d rdy=%b count=%h exp=0,%h", w, i, ex_ready_o, trap_count_o, exp_count); end
        csr_wr_ready_i = (i == 3);
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h8000_0000 || csr_wr_valid_o !== 1'b0 || ex_ready_o !== 1'b0) begin failures++; $display("FAIL bp_redirect%0d rv=%b pc=%h wv=%b rdy=%b exp=1,80000000,0,0", j, redirect_valid_o, redirect_pc_o, csr_wr_valid_o, ex_ready_o); end
      redirect_ready_i = (j == 2);
    end
    csr_wr_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1 || busy_o !== 1'b0 || redirect_valid_o !== 1'b0) begin failures++; $display("FAIL bp_idle rdy=%b busy=%b rv=%b exp=1,0,0", ex_ready_o, busy_o, redirect_valid_o); end
    @(negedge clk_i);
    ex_valid_i = 1'b0; debug_mode_i = 1'b0;
    exp_count = sat_inc(exp_count);
    checks++; if (flush_o !== 1'b1 || trap_count_o !== exp_count) begin failures++; $display("FAIL bp_second_accept flush=%b count=%h exp=1,%h", flush_o, trap_count_o, exp_count); end
    @(negedge clk_i);
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h808 || csr_wr_valid_o !== 1'b0) begin failures++; $display("FAIL bp_second_redirect rv=%b pc=%h wv=%b exp=1,808,0", redirect_valid_o, redirect_pc_o, csr_wr_valid_o); end
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("FAIL bp_second_idle rdy=%b exp=1", ex_ready_o); end
  endtask

  task automatic test_reset_mid_epc();
    ex_valid_i = 1'b1; ex_cause_i = 64'h2; ex_tval_i = 64'h7b2; ex_pc_i = 64'h8000_0104; mtvec_i = 64'h8000_0000;
    debug_mode_i = 1'b0; csr_wr_ready_i = 1'b1; redirect_ready_i = 1'b1;
    @(negedge clk_i);
    ex_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (csr_wr_valid_o !== 1'b1 || csr_wr_addr_o !== 12'h341) begin failures++; $display("FAIL rst_in_epc v=%b addr=%h exp=1,341", csr_wr_valid_o, csr_wr_addr_o); end
    csr_wr_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    exp_count = 4'h0;
    checks++; if ({csr_wr_valid_o, flush_o, redirect_valid_o, busy_o} !== 4'b0000 || csr_wr_addr_o !== 12'h0 || csr_wr_data_o !== 64'h0) begin failures++; $display("FAIL rst_async_outputs v=%b fl=%b rv=%b busy=%b addr=%h data=%h exp=0", csr_wr_valid_o, flush_o, redirect_valid_o, busy_o, csr_wr_addr_o, csr_wr_data_o); end
    checks++; if (ex_ready_o !== 1'b1 || trap_count_o !== 4'h0) begin failures++; $display("FAIL rst_async_ready_count rdy=%b count=%h exp=1,0", ex_ready_o, trap_count_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || csr_wr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_no_retry busy=%b wv=%b exp=0,0", busy_o, csr_wr_valid_o); end
    run_normal_trap(ILLEGAL_INSTR, 64'h7b2, 64'h8000_0104, 64'h8000_0000, 64'h8000_0000, "after_rst");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) begin
      run_debug_trap(ILLEGAL_INSTR, "sat");
    end
    checks++; if (trap_count_o !== 4'hF) begin failures++; $display("FAIL sat_final got=%h exp=f", trap_count_o); end
  endtask

  initial begin
    test_reset();
    test_illegal_access();
    test_debug_mode();
    test_vector_modes();
    test_backpressure();
    test_reset_mid_epc();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
